// File: rtl/mips_mem_pkg.sv
// mips_mem_pkg
// Shared definitions for the MIPS data-memory responder:
//   - responder FSM state encoding
//   - default byte address of data word 0
//   - width of the wait-state counter
//   - helper that sizes the word-index bus for a given depth
package mips_mem_pkg;

    localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h1001_0000;
    localparam int unsigned CNT_W             = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    // Word-index width; never below 1 bit so a single-word memory still elaborates.
    function automatic int unsigned idx_width(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/mem_word_array.sv
// mem_word_array
// Single-port word storage, DEPTH_WORDS x 32 bits.
// Synchronous write, combinational read at the same address.
// Contents are not reset.
// Ports:
//   clk    - clock, writes on rising edge
//   we     - write enable
//   addr   - word index
//   wdata  - write data
//   rdata  - read data at addr
module mem_word_array #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned ADDR_W      = 10
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata
);

    logic [31:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/data_memory_responder.sv
// data_memory_responder
// Valid/ready data-memory responder for a MIPS CPU with a fixed number of
// wait states per access.
// Ports:
//   clk         - clock
//   reset       - asynchronous, active-low reset
//   req_valid   - request present
//   req_ready   - responder idle, can accept a request
//   req_write   - 1 store, 0 load
//   req_addr    - byte address
//   req_wdata   - store data
//   resp_valid  - response present
//   resp_ready  - CPU consumes response
//   resp_rdata  - load data (0 for stores and errors)
//   resp_err    - misaligned or out-of-range access
module data_memory_responder
    import mips_mem_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = DEFAULT_BASE_ADDR,
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int unsigned AW   = idx_width(DEPTH_WORDS);
    localparam logic [32:0] SPAN = 33'(DEPTH_WORDS) << 2;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic               wr_q;
    logic [31:0]        addr_q;
    logic [31:0]        wdata_q;

    logic               accept;
    logic               enter_resp;
    logic               cur_write;
    logic [31:0]        cur_addr;
    logic [31:0]        cur_wdata;
    logic [32:0]        diff;
    logic               in_range;
    logic               cur_err;
    logic               mem_we;
    logic [AW-1:0]      mem_addr;
    logic [31:0]        mem_rdata;

    assign accept = req_valid && (state_q == IDLE);

    // With zero wait states the access completes on its own acceptance edge,
    // so the live request inputs are used while still in IDLE.
    assign cur_write = (state_q == IDLE) ? req_write : wr_q;
    assign cur_addr  = (state_q == IDLE) ? req_addr  : addr_q;
    assign cur_wdata = (state_q == IDLE) ? req_wdata : wdata_q;

    // 33-bit subtraction: an address below BASE_ADDR sets bit 32 and can
    // never compare below SPAN, so no wrap-around can sneak into range.
    assign diff     = {1'b0, cur_addr} - {1'b0, BASE_ADDR};
    assign in_range = (diff < SPAN);
    assign cur_err  = (cur_addr[1:0] != 2'b00) || !in_range;
    assign mem_addr = AW'(diff >> 2);

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    state_d = (WAIT_CYCLES == 0) ? RESP : WAIT;
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        req_ready  = (state_q == IDLE);
        resp_valid = (state_q == RESP);
        enter_resp = (state_d == RESP) && (state_q != RESP);
        mem_we     = enter_resp && cur_write && !cur_err;
    end

    // Request capture, wait counter and response registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q      <= '0;
            wr_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else begin
            if (accept) begin
                wr_q    <= req_write;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                cnt_q   <= (WAIT_CYCLES > 0) ? CNT_W'(WAIT_CYCLES - 1) : '0;
            end else if ((state_q == WAIT) && (cnt_q != '0)) begin
                cnt_q <= cnt_q - 1'b1;
            end
            if (enter_resp) begin
                resp_err   <= cur_err;
                resp_rdata <= (cur_write || cur_err) ? '0 : mem_rdata;
            end
        end
    end

    mem_word_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .ADDR_W      (AW)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .addr  (mem_addr),
        .wdata (cur_wdata),
        .rdata (mem_rdata)
    );

endmodule

// File: tb/tb_data_memory_responder.sv
// tb_data_memory_responder
// Table-driven bench with a response scoreboard for data_memory_responder.
// Instance dut uses the default 2 wait states, dut_z uses 0 wait states;
// sel routes the shared stimulus to one of them.
module tb_data_memory_responder;

    typedef struct {
        logic        write;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          hold;
        string       name;
    } vec_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        string       name;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        sel = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_write = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        resp_ready = 1'b0;

    logic        a_req_valid, a_resp_ready, a_req_ready, a_resp_valid, a_resp_err;
    logic [31:0] a_resp_rdata;
    logic        z_req_valid, z_resp_ready, z_req_ready, z_resp_valid, z_resp_err;
    logic [31:0] z_resp_rdata;

    logic        v_req_ready, v_resp_valid, v_resp_err;
    logic [31:0] v_resp_rdata;

    int n_vec  = 0;
    int n_fail = 0;
    exp_t sb[$];
    vec_t vt[16];

    always #5 clk = ~clk;

    assign a_req_valid  = req_valid && !sel;
    assign a_resp_ready = resp_ready && !sel;
    assign z_req_valid  = req_valid && sel;
    assign z_resp_ready = resp_ready && sel;

    assign v_req_ready  = sel ? z_req_ready  : a_req_ready;
    assign v_resp_valid = sel ? z_resp_valid : a_resp_valid;
    assign v_resp_rdata = sel ? z_resp_rdata : a_resp_rdata;
    assign v_resp_err   = sel ? z_resp_err   : a_resp_err;

    data_memory_responder #(
        .BASE_ADDR   (32'h1001_0000),
        .DEPTH_WORDS (1024),
        .WAIT_CYCLES (2)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (a_req_valid),
        .req_ready  (a_req_ready),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (a_resp_valid),
        .resp_ready (a_resp_ready),
        .resp_rdata (a_resp_rdata),
        .resp_err   (a_resp_err)
    );

    data_memory_responder #(
        .BASE_ADDR   (32'h1001_0000),
        .DEPTH_WORDS (1024),
        .WAIT_CYCLES (0)
    ) dut_z (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (z_req_valid),
        .req_ready  (z_req_ready),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (z_resp_valid),
        .resp_ready (z_resp_ready),
        .resp_rdata (z_resp_rdata),
        .resp_err   (z_resp_err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // One complete access. Called #1 after a rising edge.
    task automatic access(input vec_t v, input int exp_lat);
        int   n;
        int   lat;
        exp_t e;
        req_valid = 1'b1;
        req_write = v.write;
        req_addr  = v.addr;
        req_wdata = v.wdata;
        n = 0;
        while (!v_req_ready && n < 50) begin
            @(posedge clk); #1; n++;
        end
        chk({v.name, "_req_ready"}, 32'(v_req_ready), 32'd1);
        sb.push_back('{rdata: v.exp_rdata, err: v.exp_err, name: v.name});
        @(posedge clk); #1;                       // acceptance edge
        req_valid  = 1'b0;
        req_write  = ~v.write;                    // later input changes must not matter
        req_addr   = 32'h1001_0000;
        req_wdata  = 32'hFFFF_FFFF;
        resp_ready = 1'b1;                        // ignored until RESP
        lat = 0;
        while (!v_resp_valid && lat < 40) begin
            @(posedge clk); #1; lat++;
        end
        chk({v.name, "_latency"}, 32'(lat), 32'(exp_lat));
        if (sb.size() == 0) begin
            chk({v.name, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            chk({e.name, "_rdata"}, v_resp_rdata, e.rdata);
            chk({e.name, "_err"}, 32'(v_resp_err), 32'(e.err));
        end
        if (v.hold > 0) begin
            resp_ready = 1'b0;
            for (int i = 0; i < v.hold; i++) begin
                @(posedge clk); #1;
                chk({v.name, "_hold_valid"}, 32'(v_resp_valid), 32'd1);
                chk({v.name, "_hold_rdata"}, v_resp_rdata, v.exp_rdata);
                chk({v.name, "_hold_err"}, 32'(v_resp_err), 32'(v.exp_err));
                chk({v.name, "_hold_req_ready"}, 32'(v_req_ready), 32'd0);
            end
            resp_ready = 1'b1;
        end
        @(posedge clk); #1;                       // completion edge
        resp_ready = 1'b0;
        chk({v.name, "_done_req_ready"}, 32'(v_req_ready), 32'd1);
        chk({v.name, "_done_valid"}, 32'(v_resp_valid), 32'd0);
    endtask

    initial begin
        vt[0]  = '{1'b1, 32'h1001_0000, 32'hA5A5_0000, 32'h0,          1'b0, 0, "st_word0"};
        vt[1]  = '{1'b1, 32'h1001_0008, 32'hDEAD_BEEF, 32'h0,          1'b0, 0, "st_deadbeef"};
        vt[2]  = '{1'b0, 32'h1001_0008, 32'h0,         32'hDEAD_BEEF, 1'b0, 5, "ld_deadbeef_hold"};
        vt[3]  = '{1'b0, 32'h1001_0002, 32'h0,         32'h0,          1'b1, 0, "ld_misaligned"};
        vt[4]  = '{1'b1, 32'h1000_FFFC, 32'h1,         32'h0,          1'b1, 0, "st_below_base"};
        vt[5]  = '{1'b0, 32'h1001_0000, 32'h0,         32'hA5A5_0000, 1'b0, 0, "ld_word0"};
        vt[6]  = '{1'b1, 32'h1001_0FFC, 32'hCAFE_F00D, 32'h0,          1'b0, 0, "st_last"};
        vt[7]  = '{1'b0, 32'h1001_0FFC, 32'h0,         32'hCAFE_F00D, 1'b0, 0, "ld_last"};
        vt[8]  = '{1'b0, 32'h1001_1000, 32'h0,         32'h0,          1'b1, 0, "ld_past_end"};
        vt[9]  = '{1'b1, 32'h1001_0010, 32'h0BAD_F00D, 32'h0,          1'b0, 0, "st_prior"};
        vt[10] = '{1'b0, 32'h1001_0010, 32'h0,         32'h0BAD_F00D, 1'b0, 0, "ld_prior"};
        vt[11] = '{1'b1, 32'h1001_0004, 32'h1111_2222, 32'h0,          1'b0, 0, "st_word1"};
        vt[12] = '{1'b0, 32'h1001_0004, 32'h0,         32'h1111_2222, 1'b0, 0, "ld_word1"};
        vt[13] = '{1'b0, 32'hFFFF_FFFC, 32'h0,         32'h0,          1'b1, 0, "ld_top_addr"};
        vt[14] = '{1'b1, 32'h1001_000A, 32'h0,         32'h0,          1'b1, 0, "st_misaligned"};
        vt[15] = '{1'b0, 32'h1001_0008, 32'h0,         32'hDEAD_BEEF, 1'b0, 0, "ld_after_bad_st"};

        // Reset state
        #12;
        chk("rst_resp_valid", 32'(a_resp_valid), 32'd0);
        chk("rst_resp_rdata", a_resp_rdata, 32'd0);
        chk("rst_resp_err", 32'(a_resp_err), 32'd0);
        chk("rst_req_ready", 32'(a_req_ready), 32'd1);
        @(posedge clk); #3;
        reset = 1'b1;
        @(posedge clk); #1;
        chk("rel_req_ready", 32'(a_req_ready), 32'd1);
        chk("rel_z_req_ready", 32'(z_req_ready), 32'd1);

        // Table on the 2-wait-state instance
        sel = 1'b0;
        for (int i = 0; i < 16; i++) begin
            access(vt[i], 2);
        end

        // Reset pulsed while a store sits in WAIT
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 32'h1001_0010;
        req_wdata = 32'h1234_5678;
        @(posedge clk); #1;                       // accepted
        req_valid = 1'b0;
        @(posedge clk); #1;                       // still in WAIT
        chk("wait_resp_valid", 32'(a_resp_valid), 32'd0);
        reset = 1'b0;
        #1;
        chk("arst_resp_valid", 32'(a_resp_valid), 32'd0);
        chk("arst_resp_rdata", a_resp_rdata, 32'd0);
        chk("arst_resp_err", 32'(a_resp_err), 32'd0);
        chk("arst_req_ready", 32'(a_req_ready), 32'd1);
        @(posedge clk); #3;
        reset = 1'b1;
        @(posedge clk); #1;
        chk("arst_rel_req_ready", 32'(a_req_ready), 32'd1);
        access('{1'b0, 32'h1001_0010, 32'h0, 32'h0BAD_F00D, 1'b0, 0, "ld_after_abort"}, 2);

        // Zero-wait-state instance
        sel = 1'b1;
        access('{1'b1, 32'h1001_0000, 32'h5555_AAAA, 32'h0,          1'b0, 0, "z_st_word0"}, 0);
        access('{1'b0, 32'h1001_0000, 32'h0,         32'h5555_AAAA, 1'b0, 2, "z_ld_word0"}, 0);
        access('{1'b0, 32'h1001_1000, 32'h0,         32'h0,          1'b1, 0, "z_ld_past_end"}, 0);
        sel = 1'b0;

        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1, "timeout");
    end

endmodule
